// File: rtl/grant_sequencer.sv
// grant_sequencer: queues one burst job per client, raises requests to an
// external arbiter, and sequences beats for the granted client while holding
// the grant with lock until the burst completes.
module grant_sequencer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_wr,
  input  logic [1:0]       job_client,
  input  logic [CNT_W-1:0] job_len,
  input  logic [1:0]       grant_id,
  input  logic             valid,
  output logic [3:0]       req,
  output logic             lock,
  output logic [3:0]       pending,
  output logic             beat,
  output logic [1:0]       beat_client,
  output logic [3:0]       done,
  output logic             err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BURST   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       owner;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q [4];
  logic             job_ok;

  // A job is taken only for an idle client with a non-zero length.
  assign job_ok = job_wr && !pending[job_client] && (job_len != '0);

  // Request lines mirror the registered pending vector.
  assign req = pending;

  // Per-client burst length storage; intentionally not reset.
  always_ff @(posedge clk) begin
    if (job_ok) begin
      len_q[job_client] <= job_len;
    end
  end

  // Job intake, burst FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= '0;
      cnt         <= '0;
      pending     <= '0;
      lock        <= 1'b0;
      beat        <= 1'b0;
      beat_client <= '0;
      done        <= '0;
      err         <= 1'b0;
    end else begin
      beat        <= 1'b0;
      beat_client <= '0;
      done        <= '0;
      err         <= job_wr && !job_ok;

      // Accepted client is never the owner (owner is still pending), so the
      // set here and the clear below never touch the same bit.
      if (job_ok) begin
        pending[job_client] <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (valid && pending[grant_id]) begin
            owner <= grant_id;
            cnt   <= len_q[grant_id];
            lock  <= 1'b1;
            state <= BURST;
          end
        end
        BURST: begin
          if (valid && (grant_id == owner)) begin
            beat        <= 1'b1;
            beat_client <= owner;
            cnt         <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              pending[owner] <= 1'b0;
              done[owner]    <= 1'b1;
              lock           <= 1'b0;
              state          <= RELEASE;
            end
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grant_sequencer.sv
// tb_grant_sequencer: table-driven vectors plus directed multi-cycle
// sequences for grant_sequencer.
module tb_grant_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       job_wr = 1'b0;
  logic [1:0] job_client = '0;
  logic [3:0] job_len = '0;
  logic [1:0] grant_id = '0;
  logic       valid = 1'b0;
  logic [3:0] req;
  logic       lock;
  logic [3:0] pending;
  logic       beat;
  logic [1:0] beat_client;
  logic [3:0] done;
  logic       err;

  int checks = 0;
  int errors = 0;

  grant_sequencer #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .job_wr     (job_wr),
    .job_client (job_client),
    .job_len    (job_len),
    .grant_id   (grant_id),
    .valid      (valid),
    .req        (req),
    .lock       (lock),
    .pending    (pending),
    .beat       (beat),
    .beat_client(beat_client),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       jw;
    logic [1:0] jc;
    logic [3:0] jl;
    logic [1:0] gid;
    logic       vld;
    logic [3:0] e_req;
    logic       e_lock;
    logic       e_beat;
    logic [1:0] e_bc;
    logic [3:0] e_done;
    logic       e_err;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic jw, input logic [1:0] jc,
                       input logic [3:0] jl, input logic [1:0] gid, input logic vld);
    rst_n = r; job_wr = jw; job_client = jc; job_len = jl; grant_id = gid; valid = vld;
  endtask

  // Advance one clock and let outputs settle past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0);
    step();
    drive(1'b1, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0);
  endtask

  function automatic vec_t mk(input logic r, input logic jw, input logic [1:0] jc,
                              input logic [3:0] jl, input logic [1:0] gid, input logic vld,
                              input logic [3:0] rq, input logic lk, input logic bt,
                              input logic [1:0] bc, input logic [3:0] dn, input logic er);
    vec_t v;
    v.rst = r; v.jw = jw; v.jc = jc; v.jl = jl; v.gid = gid; v.vld = vld;
    v.e_req = rq; v.e_lock = lk; v.e_beat = bt; v.e_bc = bc; v.e_done = dn; v.e_err = er;
    return v;
  endfunction

  initial begin
    int nb;
    int nd;
    int nb_at_done;
    int vp [6];

    //          rst jw jc    jl     gid  vld   req      lk bt bc    done     err
    tbl[0]  = mk(0, 0, 2'd0, 4'd0, 2'd0, 0,   4'b0000, 0, 0, 2'd0, 4'b0000, 0);
    tbl[1]  = mk(1, 1, 2'd2, 4'd3, 2'd0, 0,   4'b0100, 0, 0, 2'd0, 4'b0000, 0);
    tbl[2]  = mk(1, 0, 2'd0, 4'd0, 2'd2, 1,   4'b0100, 1, 0, 2'd0, 4'b0000, 0);
    tbl[3]  = mk(1, 0, 2'd0, 4'd0, 2'd2, 1,   4'b0100, 1, 1, 2'd2, 4'b0000, 0);
    tbl[4]  = mk(1, 0, 2'd0, 4'd0, 2'd2, 1,   4'b0100, 1, 1, 2'd2, 4'b0000, 0);
    tbl[5]  = mk(1, 0, 2'd0, 4'd0, 2'd2, 1,   4'b0000, 0, 1, 2'd2, 4'b0100, 0);
    tbl[6]  = mk(1, 0, 2'd0, 4'd0, 2'd2, 1,   4'b0000, 0, 0, 2'd0, 4'b0000, 0);
    tbl[7]  = mk(1, 0, 2'd0, 4'd0, 2'd2, 1,   4'b0000, 0, 0, 2'd0, 4'b0000, 0);
    tbl[8]  = mk(1, 1, 2'd0, 4'd0, 2'd0, 0,   4'b0000, 0, 0, 2'd0, 4'b0000, 1);
    tbl[9]  = mk(1, 0, 2'd0, 4'd0, 2'd1, 1,   4'b0000, 0, 0, 2'd0, 4'b0000, 0);
    tbl[10] = mk(1, 1, 2'd1, 4'd1, 2'd1, 1,   4'b0010, 0, 0, 2'd0, 4'b0000, 0);
    tbl[11] = mk(1, 0, 2'd0, 4'd0, 2'd1, 1,   4'b0010, 1, 0, 2'd0, 4'b0000, 0);
    tbl[12] = mk(1, 0, 2'd0, 4'd0, 2'd1, 1,   4'b0000, 0, 1, 2'd1, 4'b0010, 0);
    tbl[13] = mk(1, 1, 2'd1, 4'd2, 2'd0, 0,   4'b0010, 0, 0, 2'd0, 4'b0000, 0);
    tbl[14] = mk(0, 0, 2'd0, 4'd0, 2'd0, 0,   4'b0000, 0, 0, 2'd0, 4'b0000, 0);
    tbl[15] = mk(1, 0, 2'd0, 4'd0, 2'd0, 0,   4'b0000, 0, 0, 2'd0, 4'b0000, 0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst, tbl[i].jw, tbl[i].jc, tbl[i].jl, tbl[i].gid, tbl[i].vld);
      step();
      chk($sformatf("tbl%0d.req", i),     8'(req),         8'(tbl[i].e_req));
      chk($sformatf("tbl%0d.pending", i), 8'(pending),     8'(tbl[i].e_req));
      chk($sformatf("tbl%0d.lock", i),    8'(lock),        8'(tbl[i].e_lock));
      chk($sformatf("tbl%0d.beat", i),    8'(beat),        8'(tbl[i].e_beat));
      chk($sformatf("tbl%0d.bclient", i), 8'(beat_client), 8'(tbl[i].e_bc));
      chk($sformatf("tbl%0d.done", i),    8'(done),        8'(tbl[i].e_done));
      chk($sformatf("tbl%0d.err", i),     8'(err),         8'(tbl[i].e_err));
    end

    // Two clients pending, arbiter grants 3 then 1.
    do_reset();
    drive(1, 1, 2'd1, 4'd2, 2'd0, 0); step();
    drive(1, 1, 2'd3, 4'd2, 2'd0, 0); step();
    chk("two.req", 8'(req), 8'h0a);
    drive(1, 0, 2'd0, 4'd0, 2'd3, 1); step();
    chk("two.cap3.lock", 8'(lock), 8'h1);
    step();
    chk("two.b1.beat", 8'({beat, beat_client}), 8'h7);
    step();
    chk("two.b2.beat", 8'({beat, beat_client}), 8'h7);
    chk("two.b2.done", 8'(done), 8'h8);
    chk("two.b2.lock", 8'(lock), 8'h0);
    drive(1, 0, 2'd0, 4'd0, 2'd1, 1); step();
    chk("two.rel.lock", 8'(lock), 8'h0);
    chk("two.rel.beat", 8'(beat), 8'h0);
    step();
    chk("two.cap1.lock", 8'(lock), 8'h1);
    step();
    chk("two.b3.beat", 8'({beat, beat_client}), 8'h5);
    step();
    chk("two.b4.beat", 8'({beat, beat_client}), 8'h5);
    chk("two.b4.done", 8'(done), 8'h2);
    chk("two.end.req", 8'(req), 8'h0);

    // Stalls mid-burst, new job during burst, and rejected job to the owner.
    do_reset();
    drive(1, 1, 2'd0, 4'd4, 2'd0, 0); step();
    chk("stall.req", 8'(req), 8'h1);
    drive(1, 0, 2'd0, 4'd0, 2'd0, 1); step();
    chk("stall.cap.lock", 8'(lock), 8'h1);
    vp = '{1, 1, 0, 0, 1, 1};
    nb = 0;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, (i == 0) || (i == 2), (i == 0) ? 2'd2 : 2'd0, (i == 0) ? 4'd1 : 4'd7,
            2'd0, vp[i][0]);
      step();
      chk($sformatf("stall%0d.beat", i), 8'(beat), 8'(vp[i]));
      chk($sformatf("stall%0d.err", i), 8'(err), (i == 2) ? 8'h1 : 8'h0);
      chk($sformatf("stall%0d.lock", i), 8'(lock), (i == 5) ? 8'h0 : 8'h1);
      if (beat) nb++;
      if (done != 4'b0000) nd++;
    end
    chk("stall.beats", 8'(nb), 8'd4);
    chk("stall.dones", 8'(nd), 8'd1);
    chk("stall.end.req", 8'(req), 8'h4);

    // Reset on the second beat of a 5-beat burst, then a fresh job.
    do_reset();
    drive(1, 1, 2'd1, 4'd5, 2'd0, 0); step();
    drive(1, 0, 2'd0, 4'd0, 2'd1, 1); step();
    step();
    chk("rst.b1.beat", 8'(beat), 8'h1);
    drive(0, 0, 2'd0, 4'd0, 2'd1, 1); step();
    chk("rst.outs", 8'({req, lock, beat, beat_client}), 8'h00);
    chk("rst.done", 8'({done, err}), 8'h00);
    drive(1, 0, 2'd0, 4'd0, 2'd1, 1); step();
    chk("rst.after.done", 8'(done), 8'h0);
    chk("rst.after.lock", 8'(lock), 8'h0);
    drive(1, 1, 2'd3, 4'd1, 2'd0, 0); step();
    chk("rst.new.req", 8'(req), 8'h8);
    drive(1, 0, 2'd0, 4'd0, 2'd3, 1); step();
    chk("rst.new.lock", 8'(lock), 8'h1);
    step();
    chk("rst.new.beat", 8'({beat, beat_client}), 8'h7);
    chk("rst.new.done", 8'(done), 8'h8);
    step();
    chk("rst.new.rel", 8'({lock, beat}), 8'h0);

    // Maximum length burst: exactly 15 beats, done on the last.
    do_reset();
    drive(1, 1, 2'd0, 4'd15, 2'd0, 0); step();
    drive(1, 0, 2'd0, 4'd0, 2'd0, 1); step();
    nb = 0;
    nd = 0;
    nb_at_done = -1;
    for (int k = 0; k < 24; k++) begin
      step();
      if (beat) nb++;
      if (done != 4'b0000) begin
        nd++;
        nb_at_done = nb;
      end
    end
    chk("max.beats", 8'(nb), 8'd15);
    chk("max.dones", 8'(nd), 8'd1);
    chk("max.done_at", 8'(nb_at_done), 8'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
